// File: rtl/load_store_sequencer_pkg.sv
// Shared types for the data-memory load/store sequencer: access-size encoding,
// sequencer states and the write-lane payload.
package load_store_sequencer_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    NONE               = 3'd0,
    BYTE               = 3'd1,
    HALF_WORD          = 3'd2,
    WORD               = 3'd3,
    BYTE_UNSIGNED      = 3'd4,
    HALF_WORD_UNSIGNED = 3'd5
  } truncSrc;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsuState;

  typedef struct packed {
    logic [STRB_WIDTH-1:0] wstrb;
    logic [DATA_WIDTH-1:0] wdata;
  } lsu_wlane_t;

  // NONE and the two unencoded values are illegal access sizes.
  function automatic logic trunc_legal(input logic [2:0] t);
    return (t != 3'(NONE)) && (t <= 3'(HALF_WORD_UNSIGNED));
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte strobes, store-data replication, word-aligned
// address, load extraction/extension and misalignment detection.
module lsu_data_align
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [2:0]            trunc,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] addr_aligned,
  output lsu_wlane_t            wlane,
  output logic [DATA_WIDTH-1:0] rdata_ext,
  output logic                  misaligned
);

  logic [1:0]            off;
  logic [1:0]            eoff;
  logic [DATA_WIDTH-1:0] shifted;

  assign addr_aligned = {addr[ADDR_WIDTH-1:2], 2'b00};

  // Misaligned halves/words are force-aligned by clearing the offending offset bits.
  always_comb begin
    off        = addr[1:0];
    eoff       = off;
    misaligned = 1'b0;
    wlane      = '0;
    rdata_ext  = '0;
    case (trunc)
      HALF_WORD, HALF_WORD_UNSIGNED: begin
        misaligned = off[0];
        eoff       = {off[1], 1'b0};
      end
      WORD: begin
        misaligned = (off != 2'd0);
        eoff       = 2'd0;
      end
      default: ;
    endcase
    shifted = rdata >> {eoff, 3'b000};
    case (trunc)
      BYTE, BYTE_UNSIGNED: begin
        wlane.wstrb = STRB_WIDTH'(1) << eoff;
        wlane.wdata = {4{wdata[7:0]}};
        rdata_ext   = (trunc == BYTE) ? {{24{shifted[7]}}, shifted[7:0]}
                                      : {24'd0, shifted[7:0]};
      end
      HALF_WORD, HALF_WORD_UNSIGNED: begin
        wlane.wstrb = STRB_WIDTH'(3) << eoff;
        wlane.wdata = {2{wdata[15:0]}};
        rdata_ext   = (trunc == HALF_WORD) ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'd0, shifted[15:0]};
      end
      WORD: begin
        wlane.wstrb = '1;
        wlane.wdata = wdata;
        rdata_ext   = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Sequences pipeline loads/stores onto a valid/ready data-memory bus with a watchdog.
// Define LSU_MISALIGNED_TRAP_EN to trap misaligned accesses instead of force-aligning.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_trunc,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  stall,
  output logic                  fault
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef LSU_MISALIGNED_TRAP_EN
  localparam bit TRAP_MISALIGNED = 1'b1;
`else
  localparam bit TRAP_MISALIGNED = 1'b0;
`endif

  lsuState               state_q, state_d;
  logic [2:0]            trunc_q, trunc_d;
  logic [1:0]            off_q, off_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_d, mem_valid_d, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, resp_rdata_d;
  logic                  resp_valid_d, fault_d, done;

  logic [2:0]            al_trunc;
  logic [ADDR_WIDTH-1:0] al_addr, al_addr_aligned;
  lsu_wlane_t            al_wlane;
  logic [DATA_WIDTH-1:0] al_rdata_ext;
  logic                  al_misaligned;

  // Align the incoming op while idle, the captured op while in flight.
  assign al_trunc = (state_q == IDLE) ? req_trunc : trunc_q;
  assign al_addr  = (state_q == IDLE) ? req_addr : ADDR_WIDTH'(off_q);

  lsu_data_align #(.ADDR_WIDTH(ADDR_WIDTH)) u_align (
    .trunc        (al_trunc),
    .addr         (al_addr),
    .wdata        (req_wdata),
    .rdata        (mem_rdata),
    .addr_aligned (al_addr_aligned),
    .wlane        (al_wlane),
    .rdata_ext    (al_rdata_ext),
    .misaligned   (al_misaligned)
  );

  assign stall = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT_R);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    trunc_d      = trunc_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid;
    mem_write_d  = mem_write;
    mem_addr_d   = mem_addr;
    mem_wstrb_d  = mem_wstrb;
    mem_wdata_d  = mem_wdata;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    fault_d      = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!trunc_legal(req_trunc) || (TRAP_MISALIGNED && al_misaligned)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
          end else begin
            state_d     = REQ;
            trunc_d     = req_trunc;
            off_d       = req_addr[1:0];
            cnt_d       = '0;
            mem_valid_d = 1'b1;
            mem_write_d = req_write;
            mem_addr_d  = al_addr_aligned;
            mem_wstrb_d = req_write ? al_wlane.wstrb : '0;
            mem_wdata_d = req_write ? al_wlane.wdata : '0;
          end
        end
      end
      REQ, WAIT_R: begin
        if ((state_q == REQ) && mem_ready) begin
          mem_valid_d = 1'b0;
          if (mem_write || mem_rvalid) done = 1'b1;
          else state_d = WAIT_R;
        end else if ((state_q == WAIT_R) && mem_rvalid) begin
          done = 1'b1;
        end
        // A completing access wins over a watchdog expiry in the same cycle.
        if (done) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_write ? '0 : al_rdata_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          mem_valid_d  = 1'b0;
          resp_valid_d = 1'b1;
          fault_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      trunc_q    <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      trunc_q    <= trunc_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      mem_valid  <= mem_valid_d;
      mem_write  <= mem_write_d;
      mem_addr   <= mem_addr_d;
      mem_wstrb  <= mem_wstrb_d;
      mem_wdata  <= mem_wdata_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed self-checking bench for load_store_sequencer; honours LSU_MISALIGNED_TRAP_EN.
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_trunc;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_write;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall, fault;

  int n_cmp = 0;
  int n_err = 0;

  load_store_sequencer #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_trunc  (req_trunc),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .stall      (stall),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accepting edge.
  task automatic issue(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_trunc = t;
    req_addr  = a;
    req_wdata = d;
    #1;
    check("issue_stall", 32'(stall), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int dly, input logic [31:0] e_addr,
                          input logic [3:0] e_strb, input logic [31:0] e_wdata);
    issue(1'b1, t, a, d);
    check({tag, "_mvalid"}, 32'(mem_valid), 32'd1);
    check({tag, "_mwrite"}, 32'(mem_write), 32'd1);
    check({tag, "_maddr"}, mem_addr, e_addr);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(e_strb));
    check({tag, "_wdata"}, mem_wdata, e_wdata);
    for (int i = 0; i < dly; i++) begin
      tick();
      check({tag, "_hold_mvalid"}, 32'(mem_valid), 32'd1);
      check({tag, "_hold_stall"}, 32'(stall), 32'd1);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check({tag, "_resp"}, 32'(resp_valid), 32'd1);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    tick();
    check({tag, "_resp_once"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] rd, input bit same, input logic [31:0] e_rdata);
    issue(1'b0, t, a, 32'h0);
    check({tag, "_mvalid"}, 32'(mem_valid), 32'd1);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    mem_ready  = 1'b1;
    mem_rvalid = same;
    mem_rdata  = rd;
    tick();
    mem_ready = 1'b0;
    if (!same) begin
      check({tag, "_waitr_resp"}, 32'(resp_valid), 32'd0);
      check({tag, "_waitr_stall"}, 32'(stall), 32'd1);
      mem_rvalid = 1'b1;
      tick();
    end
    mem_rvalid = 1'b0;
    check({tag, "_resp"}, 32'(resp_valid), 32'd1);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_rdata"}, resp_rdata, e_rdata);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0] bad_t[3];
    int n;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_trunc  = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) tick();

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset_n = 1'b1;
    tick();

    do_store("sw",  WORD,          32'h100, 32'hDEADBEEF, 2, 32'h100, 4'hF, 32'hDEADBEEF);
    do_store("sb",  BYTE,          32'h103, 32'h000000A5, 0, 32'h100, 4'h8, 32'hA5A5A5A5);
    do_store("sh",  HALF_WORD,     32'h102, 32'h0000BEEF, 1, 32'h100, 4'hC, 32'hBEEFBEEF);
    do_store("sbu", BYTE_UNSIGNED, 32'h001, 32'h12345677, 0, 32'h000, 4'h2, 32'h77777777);

    do_load("lb",  BYTE,               32'h102, 32'h12F45678, 1'b1, 32'hFFFFFFF4);
    do_load("lbu", BYTE_UNSIGNED,      32'h102, 32'h12F45678, 1'b0, 32'h000000F4);
    do_load("lh",  HALF_WORD,          32'h102, 32'h12F45678, 1'b1, 32'h000012F4);
    do_load("lhu", HALF_WORD_UNSIGNED, 32'h102, 32'h12F45678, 1'b0, 32'h000012F4);
    do_load("lh_neg", HALF_WORD,       32'h000, 32'h1234C001, 1'b0, 32'hFFFFC001);
    do_load("lw",  WORD,               32'h200, 32'h80000001, 1'b1, 32'h80000001);

    // Illegal size encodings complete immediately with a fault and no bus request.
    bad_t[0] = NONE;
    bad_t[1] = 3'd6;
    bad_t[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, bad_t[i], 32'h200, 32'h0);
      check("ill_mvalid", 32'(mem_valid), 32'd0);
      check("ill_resp", 32'(resp_valid), 32'd1);
      check("ill_fault", 32'(fault), 32'd1);
      check("ill_rdata", resp_rdata, 32'd0);
      tick();
      check("ill_resp_once", 32'(resp_valid), 32'd0);
    end

    // Watchdog: bus never ready.
    mem_rdata = 32'hFFFFFFFF;
    issue(1'b0, WORD, 32'h300, 32'h0);
    n = 0;
    while (mem_valid && n < 400) begin
      n++;
      tick();
    end
    check("to_cycles", 32'(n), 32'd255);
    check("to_mvalid", 32'(mem_valid), 32'd0);
    check("to_resp", 32'(resp_valid), 32'd1);
    check("to_fault", 32'(fault), 32'd1);
    check("to_rdata", resp_rdata, 32'd0);
    tick();
    check("to_ready", 32'(req_ready), 32'd1);

`ifdef LSU_MISALIGNED_TRAP_EN
    issue(1'b0, WORD, 32'h101, 32'h0);
    check("mis_lw_mvalid", 32'(mem_valid), 32'd0);
    check("mis_lw_resp", 32'(resp_valid), 32'd1);
    check("mis_lw_fault", 32'(fault), 32'd1);
    check("mis_lw_rdata", resp_rdata, 32'd0);
    tick();
    issue(1'b1, HALF_WORD, 32'h103, 32'h1234);
    check("mis_sh_mvalid", 32'(mem_valid), 32'd0);
    check("mis_sh_fault", 32'(fault), 32'd1);
    tick();
`else
    issue(1'b0, WORD, 32'h101, 32'h0);
    check("mis_lw_mvalid", 32'(mem_valid), 32'd1);
    check("mis_lw_maddr", mem_addr, 32'h100);
    mem_ready  = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick();
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    check("mis_lw_resp", 32'(resp_valid), 32'd1);
    check("mis_lw_fault", 32'(fault), 32'd0);
    check("mis_lw_rdata", resp_rdata, 32'hCAFEF00D);
    tick();
    do_store("mis_sh", HALF_WORD, 32'h103, 32'h00001234, 0, 32'h100, 4'hC, 32'h12341234);
    do_load("mis_lh", HALF_WORD, 32'h103, 32'h80010000, 1'b1, 32'hFFFF8001);
`endif

    // Asynchronous reset while waiting for read data.
    issue(1'b0, BYTE, 32'h400, 32'h0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("wr_stall", 32'(stall), 32'd1);
    check("wr_resp", 32'(resp_valid), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mvalid", 32'(mem_valid), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_resp", 32'(resp_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    tick();
    reset_n    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11223344;
    tick();
    mem_rvalid = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) n++;
      tick();
    end
    check("arst_no_resp", 32'(n), 32'd0);
    check("arst_idle_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_sequencer.md
Name: load_store_sequencer

Overview:
- Controller that sequences every data-memory access of the RISC-V pipeline.
- Accepts one load/store per transaction from the memory stage and drives a valid/ready data-memory bus.
- Generates byte strobes and store-data replication from truncSrc, and sign/zero-extends load data.
- Holds the pipeline stalled until the response returns; a watchdog bounds every access.

Parameters:
- ADDR_WIDTH, 32, byte-address width; data bus fixed at 32 bits.
- TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT_R before fault; counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset. One clock; reset asynchronous, active-low.
- req_valid  in  1  memory op presented by the pipeline
- req_ready  out  1  sequencer idle, op accepted this cycle when valid
- req_write  in  1  1=store, 0=load
- req_trunc  in  3  truncSrc: access size/signedness
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-justified
- mem_valid  out  1  bus request
- mem_ready  in  1  bus accepts request
- mem_write  out  1  bus write
- mem_addr  out  ADDR_WIDTH  word-aligned address, bits[1:0]=0
- mem_wstrb  out  4  byte strobes
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores/faults
- stall  out  1  hold upstream pipeline
- fault  out  1  qualifies resp_valid: timeout, illegal trunc, or misaligned trap

Behaviour:
- Reset: state IDLE; mem_valid, mem_write, mem_wstrb, mem_addr, mem_wdata, resp_valid, resp_rdata, fault, and the timeout counter all 0. Takes effect asynchronously mid-transaction; no pending request is resumed.
- States: IDLE, REQ, WAIT_R, RESP. All bus and response outputs are registered.
- IDLE: req_ready=1.
  - req_valid with legal trunc: capture the op; go to REQ.
  - req_trunc=NONE or any unencoded value: go to RESP with fault=1 and no bus activity.
- REQ: mem_valid=1, outputs held stable until mem_ready.
  - On mem_ready with a store: go to RESP.
  - On mem_ready with a load: go to WAIT_R, or go directly to RESP if mem_rvalid is high in the same cycle (data captured).
- WAIT_R: on mem_rvalid, capture extended data; go to RESP. mem_rvalid outside REQ/WAIT_R is ignored.
- RESP: resp_valid=1 for exactly one cycle; go to IDLE. req_ready=0 in RESP, so back-to-back ops are spaced by one idle cycle.
- Timeout: counter clears on entry to REQ and counts each cycle in REQ/WAIT_R. At TIMEOUT_CYCLES: drop mem_valid, go to RESP with fault=1, resp_rdata=0.
- stall = (IDLE & req_valid) | REQ | WAIT_R. Stall is low in RESP.
- Minimum latency: store with mem_ready already high gives resp_valid 2 cycles after acceptance; load with same-cycle rvalid is the same.
- Store strobes (o = addr[1:0]):
  - BYTE: wstrb = 1<<o, wdata = {4{b}}.
  - HALF_WORD: wstrb = 3<<o, wdata = {2{h}}.
  - WORD: wstrb = 4'hF.
- Load extraction: shift mem_rdata right by 8*o, then extend:
  - BYTE / HALF_WORD: sign-extend.
  - BYTE_UNSIGNED / HALF_WORD_UNSIGNED: zero-extend.
  - WORD: as is.
- Unsigned truncs on a store are treated as the signed size.
- Misaligned access (half with o[0]=1, word with o!=0), macro absent: offending low bits forced to 0, access proceeds, fault=0.

Optional Feature:
- LSU_MISALIGNED_TRAP_EN.
- Defined: a misaligned access skips the bus, IDLE goes directly to RESP, fault=1, resp_rdata=0.
- Undefined: force-align behaviour as above; fault never reports misalignment.

Decomposition:
- Package HighLevelControl: reuse truncSrc; add typedef enum logic[1:0] lsuState {IDLE, REQ, WAIT_R, RESP}.
- Sub-module lsu_data_align (combinational): produces strobes, replicated wdata, aligned address, extended load data and misaligned flag from trunc/addr/data.
- The FSM, watchdog and registers stay in load_store_sequencer.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_ready after 2 cycles -> mem_addr 0x100, wstrb 4'hF, stall high until RESP, single resp_valid, fault 0.
- SB addr 0x103, wdata 0x000000A5 -> wstrb 4'b1000, mem_wdata 0xA5A5A5A5, mem_addr 0x100.
- Load addr 0x102, mem_rdata 0x12F45678:
  - LB -> 0xFFFFFFF4
  - LBU -> 0x000000F4
  - LH -> 0x000012F4
  - LHU -> 0x000012F4
- Load with mem_ready tied low -> after 255 cycles mem_valid drops, resp_valid with fault=1, resp_rdata=0, then req_ready=1.
- LW addr 0x101:
  - with macro -> no mem_valid, fault=1.
  - without -> mem_addr 0x100, fault=0.
- Assert reset_n low in WAIT_R -> mem_valid, stall, resp_valid 0 immediately; rvalid pulse after release produces no response.
